// File: rtl/csr_trap_regs.sv
// Machine-mode trap CSR file: trap/mret stacking of mstatus, exception latches,
// 64-bit cycle/instret counters and the ALU-facing CSR read/write port.
module csr_trap_regs #(
  parameter int                XLEN      = 32,
  parameter int                PC_SIZE   = 32,
  parameter logic [XLEN-1:0]   MTVEC_RST = 32'h0000_0080,
  parameter int                HART_ID   = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PC_SIZE-1:0] cmt_epc,
  input  logic               cmt_epc_ena,
  input  logic [XLEN-1:0]    cmt_cause,
  input  logic               cmt_cause_ena,
  input  logic [XLEN-1:0]    cmt_badaddr,
  input  logic               cmt_badaddr_ena,
  input  logic               cmt_status_ena,
  input  logic               cmt_mret_ena,
  input  logic               cmt_instret_ena,
  input  logic               ext_irq,
  input  logic               sft_irq,
  input  logic               tmr_irq,
  input  logic               csr_ena,
  input  logic               csr_wr_en,
  input  logic               csr_rd_en,
  input  logic [11:0]        csr_idx,
  input  logic [XLEN-1:0]    csr_wdata,
  output logic [XLEN-1:0]    csr_rdata,
  output logic               csr_ilegl,
  output logic [PC_SIZE-1:0] csr_epc_r,
  output logic [XLEN-1:0]    csr_mtvec_r,
  output logic               status_mie_r,
  output logic               mtie_r,
  output logic               msie_r,
  output logic               meie_r
);

  localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADDR_MISA      = 12'h301;
  localparam logic [11:0] ADDR_MIE       = 12'h304;
  localparam logic [11:0] ADDR_MTVEC     = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
  localparam logic [11:0] ADDR_MEPC      = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
  localparam logic [11:0] ADDR_MTVAL     = 12'h343;
  localparam logic [11:0] ADDR_MIP       = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
  localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

  localparam logic [XLEN-1:0]    MISA_VAL   = XLEN'(32'h4000_0100);
  localparam logic [XLEN-1:0]    HART_VAL   = XLEN'(HART_ID);
  localparam logic [XLEN-1:0]    ALIGN_X    = {{(XLEN-2){1'b1}}, 2'b00};
  localparam logic [PC_SIZE-1:0] ALIGN_PC   = {{(PC_SIZE-2){1'b1}}, 2'b00};

  logic               mie_q;
  logic               mpie_q;
  logic               meie_q;
  logic               mtie_q;
  logic               msie_q;
  logic [XLEN-1:0]    mtvec_q;
  logic [XLEN-1:0]    mscratch_q;
  logic [PC_SIZE-1:0] mepc_q;
  logic [XLEN-1:0]    mcause_q;
  logic [XLEN-1:0]    mtval_q;
  logic [XLEN-1:0]    cyc_lo_q;
  logic [XLEN-1:0]    cyc_hi_q;
  logic [XLEN-1:0]    ins_lo_q;
  logic [XLEN-1:0]    ins_hi_q;

  logic [XLEN-1:0]    rd_val;
  logic               hit;
  logic               wr_ok;
  logic [XLEN-1:0]    cyc_lo_d;
  logic [XLEN-1:0]    cyc_hi_d;
  logic [XLEN-1:0]    ins_lo_d;
  logic [XLEN-1:0]    ins_hi_d;

  // Address decode and read mux; hit also flags the index as implemented.
  always_comb begin
    hit    = 1'b1;
    rd_val = '0;
    case (csr_idx)
      ADDR_MSTATUS: begin
        rd_val[12:11] = 2'b11;
        rd_val[7]     = mpie_q;
        rd_val[3]     = mie_q;
      end
      ADDR_MISA:      rd_val = MISA_VAL;
      ADDR_MIE: begin
        rd_val[11] = meie_q;
        rd_val[7]  = mtie_q;
        rd_val[3]  = msie_q;
      end
      ADDR_MTVEC:     rd_val = mtvec_q;
      ADDR_MSCRATCH:  rd_val = mscratch_q;
      ADDR_MEPC:      rd_val[PC_SIZE-1:0] = mepc_q;
      ADDR_MCAUSE:    rd_val = mcause_q;
      ADDR_MTVAL:     rd_val = mtval_q;
      ADDR_MIP: begin
        rd_val[11] = ext_irq;
        rd_val[7]  = tmr_irq;
        rd_val[3]  = sft_irq;
      end
      ADDR_MCYCLE:    rd_val = cyc_lo_q;
      ADDR_MCYCLEH:   rd_val = cyc_hi_q;
      ADDR_MINSTRET:  rd_val = ins_lo_q;
      ADDR_MINSTRETH: rd_val = ins_hi_q;
      ADDR_MHARTID:   rd_val = HART_VAL;
      default:        hit = 1'b0;
    endcase
  end

  // Indices 0xC00-0xFFF are read-only, so writing one of them traps as well.
  assign csr_ilegl = csr_ena & (~hit | (csr_wr_en & (csr_idx[11:10] == 2'b11)));
  assign wr_ok     = csr_ena & csr_wr_en & ~csr_ilegl;
  assign csr_rdata = (csr_ena & csr_rd_en & ~csr_ilegl) ? rd_val : '0;

  // A written half overrides its own increment; a written low half gives no carry.
  always_comb begin
    cyc_lo_d = cyc_lo_q + XLEN'(1);
    cyc_hi_d = cyc_hi_q + XLEN'(&cyc_lo_q);
    ins_lo_d = ins_lo_q + XLEN'(cmt_instret_ena);
    ins_hi_d = ins_hi_q + XLEN'(cmt_instret_ena & (&ins_lo_q));
    if (wr_ok) begin
      case (csr_idx)
        ADDR_MCYCLE: begin
          cyc_lo_d = csr_wdata;
          cyc_hi_d = cyc_hi_q;
        end
        ADDR_MCYCLEH: cyc_hi_d = csr_wdata;
        ADDR_MINSTRET: begin
          ins_lo_d = csr_wdata;
          ins_hi_d = ins_hi_q;
        end
        ADDR_MINSTRETH: ins_hi_d = csr_wdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_lo_q <= '0;
      cyc_hi_q <= '0;
      ins_lo_q <= '0;
      ins_hi_q <= '0;
    end else begin
      cyc_lo_q <= cyc_lo_d;
      cyc_hi_q <= cyc_hi_d;
      ins_lo_q <= ins_lo_d;
      ins_hi_q <= ins_hi_d;
    end
  end

  // Trap entry beats mret, and both beat a software write to mstatus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mie_q  <= 1'b0;
      mpie_q <= 1'b0;
    end else if (cmt_status_ena) begin
      mpie_q <= mie_q;
      mie_q  <= 1'b0;
    end else if (cmt_mret_ena) begin
      mie_q  <= mpie_q;
      mpie_q <= 1'b1;
    end else if (wr_ok && csr_idx == ADDR_MSTATUS) begin
      mie_q  <= csr_wdata[3];
      mpie_q <= csr_wdata[7];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mepc_q   <= '0;
      mcause_q <= '0;
      mtval_q  <= '0;
    end else begin
      if (cmt_epc_ena)
        mepc_q <= cmt_epc & ALIGN_PC;
      else if (wr_ok && csr_idx == ADDR_MEPC)
        mepc_q <= csr_wdata[PC_SIZE-1:0] & ALIGN_PC;
      if (cmt_cause_ena)
        mcause_q <= cmt_cause;
      else if (wr_ok && csr_idx == ADDR_MCAUSE)
        mcause_q <= csr_wdata;
      if (cmt_badaddr_ena)
        mtval_q <= cmt_badaddr;
      else if (wr_ok && csr_idx == ADDR_MTVAL)
        mtval_q <= csr_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meie_q     <= 1'b0;
      mtie_q     <= 1'b0;
      msie_q     <= 1'b0;
      mtvec_q    <= MTVEC_RST;
      mscratch_q <= '0;
    end else if (wr_ok) begin
      case (csr_idx)
        ADDR_MIE: begin
          meie_q <= csr_wdata[11];
          mtie_q <= csr_wdata[7];
          msie_q <= csr_wdata[3];
        end
        ADDR_MTVEC:    mtvec_q    <= csr_wdata & ALIGN_X;
        ADDR_MSCRATCH: mscratch_q <= csr_wdata;
        default: ;
      endcase
    end
  end

  assign csr_epc_r    = mepc_q;
  assign csr_mtvec_r  = mtvec_q;
  assign status_mie_r = mie_q;
  assign mtie_r       = mtie_q;
  assign msie_r       = msie_q;
  assign meie_r       = meie_q;

endmodule

// File: tb/tb_csr_trap_regs.sv
// Bench for csr_trap_regs: directed vector table, reset/corner sequences and
// randomized traffic checked against an architectural model of the CSRs.
module tb_csr_trap_regs;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cmt_epc, cmt_cause, cmt_badaddr, csr_wdata;
  logic        cmt_epc_ena, cmt_cause_ena, cmt_badaddr_ena, cmt_status_ena;
  logic        cmt_mret_ena, cmt_instret_ena, ext_irq, sft_irq, tmr_irq;
  logic        csr_ena, csr_wr_en, csr_rd_en;
  logic [11:0] csr_idx;
  logic [31:0] csr_rdata, csr_epc_r, csr_mtvec_r;
  logic        csr_ilegl, status_mie_r, mtie_r, msie_r, meie_r;

  csr_trap_regs dut (
    .clk(clk), .rst(rst),
    .cmt_epc(cmt_epc), .cmt_epc_ena(cmt_epc_ena),
    .cmt_cause(cmt_cause), .cmt_cause_ena(cmt_cause_ena),
    .cmt_badaddr(cmt_badaddr), .cmt_badaddr_ena(cmt_badaddr_ena),
    .cmt_status_ena(cmt_status_ena), .cmt_mret_ena(cmt_mret_ena),
    .cmt_instret_ena(cmt_instret_ena),
    .ext_irq(ext_irq), .sft_irq(sft_irq), .tmr_irq(tmr_irq),
    .csr_ena(csr_ena), .csr_wr_en(csr_wr_en), .csr_rd_en(csr_rd_en),
    .csr_idx(csr_idx), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .csr_ilegl(csr_ilegl),
    .csr_epc_r(csr_epc_r), .csr_mtvec_r(csr_mtvec_r),
    .status_mie_r(status_mie_r), .mtie_r(mtie_r), .msie_r(msie_r), .meie_r(meie_r)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        ena, wr, rd;
    bit [11:0] idx;
    bit [31:0] wdata;
    bit        st, mret, epc_en, cause_en, bad_en, inst;
    bit [31:0] epc, cause, bad;
    bit        ext, sft, tmr;
    bit        chk;
    bit [31:0] exp_rdata;
    bit        exp_il;
  } vec_t;

  int checks = 0;
  int failures = 0;

  // Architectural model state
  bit        m_mie, m_mpie;
  bit [31:0] m_mie_reg, m_mtvec, m_scratch, m_mepc, m_mcause, m_mtval;
  bit [63:0] m_cycle, m_instret;

  function automatic void model_reset();
    m_mie = 0; m_mpie = 0; m_mie_reg = 0; m_mtvec = 32'h80; m_scratch = 0;
    m_mepc = 0; m_mcause = 0; m_mtval = 0; m_cycle = 0; m_instret = 0;
  endfunction

  function automatic bit m_legal(bit [11:0] idx);
    case (idx)
      12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
      12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hF14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit m_ilegl(vec_t v);
    return v.ena && (!m_legal(v.idx) || (v.wr && v.idx[11:10] == 2'b11));
  endfunction

  function automatic bit [31:0] m_read(vec_t v);
    if (!(v.ena && v.rd) || m_ilegl(v)) return 32'h0;
    case (v.idx)
      12'h300: return 32'h1800 | (32'(m_mie) << 3) | (32'(m_mpie) << 7);
      12'h301: return 32'h4000_0100;
      12'h304: return m_mie_reg;
      12'h305: return m_mtvec;
      12'h340: return m_scratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'h344: return (32'(v.ext) << 11) | (32'(v.tmr) << 7) | (32'(v.sft) << 3);
      12'hB00: return m_cycle[31:0];
      12'hB80: return m_cycle[63:32];
      12'hB02: return m_instret[31:0];
      12'hB82: return m_instret[63:32];
      default: return 32'h0;
    endcase
  endfunction

  function automatic void model_step(vec_t v);
    bit        do_wr;
    bit [63:0] nc, ni;
    do_wr = v.ena && v.wr && !m_ilegl(v);
    nc = m_cycle + 64'd1;
    ni = m_instret + (v.inst ? 64'd1 : 64'd0);
    if (do_wr) begin
      case (v.idx)
        12'hB00: nc = {m_cycle[63:32], v.wdata};
        12'hB80: nc = {v.wdata, nc[31:0]};
        12'hB02: ni = {m_instret[63:32], v.wdata};
        12'hB82: ni = {v.wdata, ni[31:0]};
        12'h304: m_mie_reg = v.wdata & 32'h888;
        12'h305: m_mtvec = v.wdata & ~32'h3;
        12'h340: m_scratch = v.wdata;
        default: ;
      endcase
    end
    if (v.st) {m_mpie, m_mie} = {m_mie, 1'b0};
    else if (v.mret) {m_mie, m_mpie} = {m_mpie, 1'b1};
    else if (do_wr && v.idx == 12'h300) begin
      m_mie = v.wdata[3]; m_mpie = v.wdata[7];
    end
    if (v.epc_en) m_mepc = v.epc & ~32'h3;
    else if (do_wr && v.idx == 12'h341) m_mepc = v.wdata & ~32'h3;
    if (v.cause_en) m_mcause = v.cause;
    else if (do_wr && v.idx == 12'h342) m_mcause = v.wdata;
    if (v.bad_en) m_mtval = v.bad;
    else if (do_wr && v.idx == 12'h343) m_mtval = v.wdata;
    m_cycle = nc;
    m_instret = ni;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input vec_t v);
    string tag;
    tag = $sformatf("idx%h", v.idx);
    check32({"rdata_", tag}, csr_rdata, m_read(v));
    check32({"ilegl_", tag}, 32'(csr_ilegl), 32'(m_ilegl(v)));
    check32("epc_r", csr_epc_r, m_mepc);
    check32("mtvec_r", csr_mtvec_r, m_mtvec);
    check32("status_mie_r", 32'(status_mie_r), 32'(m_mie));
    check32("ie_bits", {20'h0, meie_r, 3'b0, mtie_r, 3'b0, msie_r, 3'b0},
            m_mie_reg);
    if (v.chk) begin
      check32({"tbl_rdata_", tag}, csr_rdata, v.exp_rdata);
      check32({"tbl_ilegl_", tag}, 32'(csr_ilegl), 32'(v.exp_il));
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    csr_ena = v.ena; csr_wr_en = v.wr; csr_rd_en = v.rd;
    csr_idx = v.idx; csr_wdata = v.wdata;
    cmt_status_ena = v.st; cmt_mret_ena = v.mret; cmt_instret_ena = v.inst;
    cmt_epc_ena = v.epc_en; cmt_epc = v.epc;
    cmt_cause_ena = v.cause_en; cmt_cause = v.cause;
    cmt_badaddr_ena = v.bad_en; cmt_badaddr = v.bad;
    ext_irq = v.ext; sft_irq = v.sft; tmr_irq = v.tmr;
    #1;
    checkOutput(v);
    model_step(v);
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic vec_t acc(bit ena, bit wr, bit rd, bit [11:0] idx,
                               bit [31:0] wd, bit [31:0] exp, bit il);
    vec_t v;
    v = '{default: '0};
    v.ena = ena; v.wr = wr; v.rd = rd; v.idx = idx; v.wdata = wd;
    v.chk = 1'b1; v.exp_rdata = exp; v.exp_il = il;
    return v;
  endfunction

  logic [11:0] idx_list [18];

  initial begin
    vec_t vecs[$];
    vec_t v;

    idx_list = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                 12'h342, 12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02,
                 12'hB82, 12'hF14, 12'h7C0, 12'h345, 12'hF11, 12'hC00};

    {csr_ena, csr_wr_en, csr_rd_en, cmt_status_ena, cmt_mret_ena} = '0;
    {cmt_epc_ena, cmt_cause_ena, cmt_badaddr_ena, cmt_instret_ena} = '0;
    {ext_irq, sft_irq, tmr_irq} = '0;
    csr_idx = '0; csr_wdata = '0; cmt_epc = '0; cmt_cause = '0; cmt_badaddr = '0;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    vecs.push_back(acc(1, 0, 1, 12'h305, 0, 32'h80, 0));
    vecs.push_back(acc(1, 1, 0, 12'h300, 32'h8, 0, 0));
    vecs.push_back(acc(1, 0, 1, 12'h300, 0, 32'h1808, 0));
    v = acc(0, 0, 0, 0, 0, 0, 0);
    v.st = 1; v.epc_en = 1; v.epc = 32'h1003; v.cause_en = 1; v.cause = 32'h8000_000B;
    vecs.push_back(v);
    v = acc(1, 0, 1, 12'h300, 0, 32'h1880, 0); v.mret = 1;
    vecs.push_back(v);
    vecs.push_back(acc(1, 0, 1, 12'h300, 0, 32'h1888, 0));
    vecs.push_back(acc(1, 0, 1, 12'h341, 0, 32'h1000, 0));
    vecs.push_back(acc(1, 0, 1, 12'h342, 0, 32'h8000_000B, 0));
    v = acc(1, 1, 0, 12'h341, 32'h2000, 0, 0); v.epc_en = 1; v.epc = 32'h3000;
    vecs.push_back(v);
    vecs.push_back(acc(1, 0, 1, 12'h341, 0, 32'h3000, 0));
    vecs.push_back(acc(1, 1, 0, 12'hB02, 32'hFFFF_FFFF, 0, 0));
    vecs.push_back(acc(1, 1, 0, 12'hB82, 32'h0, 0, 0));
    v = acc(1, 0, 1, 12'hB02, 0, 32'hFFFF_FFFF, 0); v.inst = 1;
    vecs.push_back(v);
    vecs.push_back(acc(1, 0, 1, 12'hB02, 0, 32'h0, 0));
    vecs.push_back(acc(1, 0, 1, 12'hB82, 0, 32'h1, 0));
    vecs.push_back(acc(1, 0, 1, 12'hB02, 0, 32'h0, 0));
    vecs.push_back(acc(1, 0, 1, 12'hB82, 0, 32'h1, 0));
    vecs.push_back(acc(1, 1, 0, 12'hF14, 32'h5, 0, 1));
    vecs.push_back(acc(1, 0, 1, 12'hF14, 0, 32'h0, 0));
    vecs.push_back(acc(1, 0, 1, 12'h7C0, 0, 32'h0, 1));
    v = acc(1, 0, 1, 12'h344, 0, 32'h880, 0); v.ext = 1; v.tmr = 1;
    vecs.push_back(v);
    vecs.push_back(acc(1, 1, 0, 12'h304, 32'hFFFF_FFFF, 0, 0));
    vecs.push_back(acc(1, 0, 1, 12'h304, 0, 32'h888, 0));
    vecs.push_back(acc(1, 1, 0, 12'h301, 32'h0, 0, 0));
    vecs.push_back(acc(1, 0, 1, 12'h301, 0, 32'h4000_0100, 0));
    v = acc(1, 1, 0, 12'h300, 32'h88, 0, 0); v.st = 1;
    vecs.push_back(v);
    vecs.push_back(acc(1, 0, 1, 12'h300, 0, 32'h1880, 0));

    foreach (vecs[i]) applyStimulus(vecs[i]);

    check32("meie_r_set", 32'(meie_r), 32'h1);
    check32("mtie_r_set", 32'(mtie_r), 32'h1);
    check32("msie_r_set", 32'(msie_r), 32'h1);

    // Asynchronous reset between clock edges
    applyStimulus(acc(1, 1, 0, 12'h305, 32'h100, 0, 0));
    applyStimulus(acc(1, 1, 0, 12'h300, 32'h8, 0, 0));
    #1 rst = 1'b1;
    #1;
    check32("rst_mtvec_r", csr_mtvec_r, 32'h80);
    check32("rst_status_mie_r", 32'(status_mie_r), 32'h0);
    check32("rst_epc_r", csr_epc_r, 32'h0);
    check32("rst_ie_bits", {29'h0, meie_r, mtie_r, msie_r}, 32'h0);
    rst = 1'b0;
    model_reset();
    applyStimulus(acc(1, 0, 1, 12'hB00, 0, 32'h0, 0));
    applyStimulus(acc(1, 0, 1, 12'hB80, 0, 32'h0, 0));

    for (int n = 0; n < 400; n++) begin
      v = '{default: '0};
      v.ena   = ($urandom_range(3) != 0);
      v.wr    = $urandom_range(1);
      v.rd    = $urandom_range(1);
      v.idx   = idx_list[$urandom_range(17)];
      v.wdata = $urandom;
      v.st    = ($urandom_range(7) == 0);
      v.mret  = ($urandom_range(7) == 0);
      v.epc_en = ($urandom_range(3) == 0);   v.epc = $urandom;
      v.cause_en = ($urandom_range(3) == 0); v.cause = $urandom;
      v.bad_en = ($urandom_range(3) == 0);   v.bad = $urandom;
      v.inst  = $urandom_range(1);
      v.ext   = $urandom_range(1);
      v.sft   = $urandom_range(1);
      v.tmr   = $urandom_range(1);
      applyStimulus(v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/csr_trap_regs.md
Name: csr_trap_regs

Overview:
- Machine-mode trap CSR file; the receiving end of the commit unit's CSR interface.
- Latches mepc/mcause/mtval on trap, stacks and unstacks mstatus MIE/MPIE on trap and mret, and counts cycles and retired instructions.
- Feeds mtvec, mepc and interrupt-enable state back to commit and PC logic.
- Serves the ALU's CSR read/write port (csrrw/csrrs/csrrc already resolved to write data upstream).

Parameters:
- XLEN, 32, CSR data width.
- PC_SIZE, 32, width of mepc.
- MTVEC_RST, 32'h0000_0080, mtvec reset value.
- HART_ID, 0, value returned by mhartid.

Ports:
- clk  in  1  core clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- cmt_epc  in  PC_SIZE  trapping PC
- cmt_epc_ena  in  1  load mepc
- cmt_cause  in  XLEN  trap cause
- cmt_cause_ena  in  1  load mcause
- cmt_badaddr  in  XLEN  faulting address or instruction
- cmt_badaddr_ena  in  1  load mtval
- cmt_status_ena  in  1  trap entry: stack mstatus
- cmt_mret_ena  in  1  mret retire: unstack mstatus
- cmt_instret_ena  in  1  one instruction retired
- ext_irq  in  1  raw external interrupt level (mip.MEIP)
- sft_irq  in  1  raw software interrupt level (mip.MSIP)
- tmr_irq  in  1  raw timer interrupt level (mip.MTIP)
- csr_ena  in  1  CSR access valid this cycle
- csr_wr_en  in  1  write requested
- csr_rd_en  in  1  read requested
- csr_idx  in  12  CSR address
- csr_wdata  in  XLEN  final write data
- csr_rdata  out  XLEN  combinational read data
- csr_ilegl  out  1  illegal access, combinational
- csr_epc_r  out  PC_SIZE  current mepc
- csr_mtvec_r  out  XLEN  current mtvec
- status_mie_r  out  1  mstatus.MIE
- mtie_r  out  1  mie.MTIE
- msie_r  out  1  mie.MSIE
- meie_r  out  1  mie.MEIE

Behaviour:

Reset:
- All registers clear asynchronously on rst=1; no clock needed.
- Exception: mtvec resets to MTVEC_RST.
- Outputs after reset: csr_epc_r=0, csr_mtvec_r=MTVEC_RST, status_mie_r=0, mtie_r=msie_r=meie_r=0.

Implemented CSRs (all others illegal):
- mstatus 0x300: MIE bit3, MPIE bit7, MPP[12:11] hardwired 2'b11, other bits read 0.
- misa 0x301: RV32I, reads 32'h4000_0100; writes ignored.
- mie 0x304: bits 3, 7, 11 writable; others 0.
- mtvec 0x305: bits[1:0] hardwired 0, direct mode only.
- mscratch 0x340: full width.
- mepc 0x341: bits[1:0] hardwired 0.
- mcause 0x342, mtval 0x343: full width.
- mip 0x344: read-only {MEIP bit11, MTIP bit7, MSIP bit3} from raw inputs; writes ignored.
- mcycle 0xB00, mcycleh 0xB80, minstret 0xB02, minstreth 0xB82: 64-bit counters.
- mhartid 0xF14: reads HART_ID.

Access rules:
- csr_rdata is valid when csr_ena&csr_rd_en; it is 0 otherwise or when illegal.
- csr_ilegl=1 when csr_ena and the index is unimplemented.
- csr_ilegl=1 when csr_ena&csr_wr_en and csr_idx[11:10]==2'b11 (read-only space).
- Illegal accesses change no state.
- Writes take effect at the next rising edge.
- A read in the same cycle as a write returns the old value.

Trap entry (cmt_status_ena=1):
- MPIE<=MIE, MIE<=0.
- Each of mepc/mcause/mtval loads independently on its own _ena.
- mepc loads {cmt_epc[PC_SIZE-1:2],2'b00}.

mret (cmt_mret_ena=1):
- MIE<=MPIE, MPIE<=1.

Priority, per register, same cycle:
- Trap-side update wins over a CSR write.
- cmt_status_ena beats cmt_mret_ena.
- A CSR write to mstatus loses to both trap and mret.

Counters:
- mcycle increments every cycle.
- minstret increments when cmt_instret_ena=1.
- 64-bit wrap from all-ones to 0; carry from low into high half in the same cycle.
- A CSR write to one half replaces that half's next value, increment included.
- The other half still advances normally, but no carry is taken from a written low half.

Test Plan:
- Reset: assert rst mid-cycle, no clock edge -> csr_mtvec_r=32'h0000_0080, status_mie_r=0, mcycle reads 0 after release.
- Trap stacking: write mstatus=32'h8, then pulse cmt_status_ena/epc_ena/cause_ena with epc=32'h0000_1003, cause=32'h8000_000B -> mstatus reads 32'h1880, mepc=32'h0000_1000, mcause=32'h8000_000B. Next cycle cmt_mret_ena -> mstatus reads 32'h1888.
- Collision: CSR write mepc=32'h2000 in the same cycle as cmt_epc_ena with epc=32'h3000 -> mepc=32'h3000.
- Counter wrap: write minstret=32'hFFFF_FFFF, minstreth=0, then one cmt_instret_ena -> minstret=0, minstreth=1. Two cycles without ena -> unchanged.
- Illegal: csr_ena&csr_wr_en on idx 0xF14 -> csr_ilegl=1, no change. Read of idx 0x7C0 -> csr_ilegl=1, csr_rdata=0.
- mip/mie: ext_irq=1, tmr_irq=1 -> mip reads 32'h880. Write mie=32'hFFFF_FFFF -> mie reads 32'h888, meie_r=mtie_r=msie_r=1.
